// File: rtl/ttc_ps_pkg25.sv
// Shared definitions for the TTC prescale controller: FSM encodings, clock-control
// field positions and the captured configuration record.
package ttc_ps_pkg25;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ARM  = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;

  localparam int unsigned CTRL_W       = 7;
  localparam int unsigned PS_EN_BIT    = 0;
  localparam int unsigned PS_VAL_LSB   = 1;
  localparam int unsigned PS_VAL_MSB   = 4;
  localparam int unsigned EXT_SEL_BIT  = 5;
  localparam int unsigned EXT_EDGE_BIT = 6;

  // Fields whose change while running forces a re-arm.
  typedef struct packed {
    logic [3:0] ps_val;
    logic       ext_sel;
  } ps_cfg_t;

endpackage

// File: rtl/ttc_ext_sync25.sv
// External clock synchroniser with a polarity-selectable, registered edge detector.
// SYNC_STAGES must be at least 2.
module ttc_ext_sync25 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk25,
  input  logic n_p_reset25,
  input  logic i_ext_clk,
  input  logic i_fall_sel,
  input  logic i_reload,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_pulse;
  logic                   w_sync_out;
  logic                   w_edge;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_edge     = i_fall_sel ? (r_hist & ~w_sync_out) : (~r_hist & w_sync_out);
  assign o_pulse    = r_pulse;

  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      r_sync  <= '0;
      r_hist  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext_clk};
      r_hist <= w_sync_out;
      // Reload drops any edge seen against pre-arm history.
      r_pulse <= i_reload ? 1'b0 : w_edge;
    end
  end

endmodule

// File: rtl/ttc_prescale_ctrl_lite25.sv
// TTC prescale controller: IDLE/ARM/RUN sequencer gating an internal or external
// source through a power-of-two prescaler into a registered count tick.
module ttc_prescale_ctrl_lite25
  import ttc_ps_pkg25::*;
#(
  parameter int unsigned PS_WIDTH    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              pclk25,
  input  logic              n_p_reset25,
  input  logic [CTRL_W-1:0] clk_ctrl_reg25,
  input  logic              count_en25,
  input  logic              restart25,
  input  logic              ext_clk25,
  output logic              count_tick25,
  output logic [1:0]        state25
);

  logic [1:0]          r_state;
  logic [1:0]          w_state_d;
  logic [PS_WIDTH-1:0] r_cnt;
  logic [PS_WIDTH-1:0] w_cnt_d;
  logic [PS_WIDTH-1:0] w_term;
  ps_cfg_t             r_cfg;
  ps_cfg_t             w_cfg_live;
  logic                r_restart;
  logic                r_tick;
  logic                w_tick_d;
  logic                w_restart_rise;
  logic                w_cfg_chg;
  logic                w_ps_en;
  logic                w_ext_pulse;
  logic                w_src_pulse;
  logic                w_reload;

  assign w_cfg_live.ps_val  = clk_ctrl_reg25[PS_VAL_MSB:PS_VAL_LSB];
  assign w_cfg_live.ext_sel = clk_ctrl_reg25[EXT_SEL_BIT];
  assign w_ps_en            = clk_ctrl_reg25[PS_EN_BIT];

  assign w_restart_rise = restart25 & ~r_restart;
  assign w_cfg_chg      = (w_cfg_live != r_cfg);
  assign w_reload       = (r_state == ST_ARM);
  assign w_src_pulse    = r_cfg.ext_sel ? w_ext_pulse : 1'b1;

  assign state25      = r_state;
  assign count_tick25 = r_tick;

  ttc_ext_sync25 #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .pclk25      (pclk25),
    .n_p_reset25 (n_p_reset25),
    .i_ext_clk   (ext_clk25),
    .i_fall_sel  (clk_ctrl_reg25[EXT_EDGE_BIT]),
    .i_reload    (w_reload),
    .o_pulse     (w_ext_pulse)
  );

  // Terminal count 2^(ps_val+1)-1, saturating to all-ones when it would not fit.
  always_comb begin
    w_term = '1;
    if (32'(r_cfg.ps_val) + 32'd1 < PS_WIDTH) begin
      w_term = PS_WIDTH'((32'd1 << (r_cfg.ps_val + 5'd1)) - 32'd1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: begin
        if (count_en25) w_state_d = ST_ARM;
      end
      ST_ARM: begin
        w_state_d = count_en25 ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!count_en25) begin
          w_state_d = ST_IDLE;
        end else if (w_restart_rise || w_cfg_chg) begin
          w_state_d = ST_ARM;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_d  = r_cnt;
    w_tick_d = 1'b0;
    if ((r_state == ST_ARM) || ((r_state == ST_IDLE) && w_restart_rise)) begin
      w_cnt_d = '0;
    end else if ((r_state == ST_RUN) && w_src_pulse) begin
      if (!w_ps_en) begin
        w_tick_d = 1'b1;
      end else if (r_cnt == w_term) begin
        w_cnt_d  = '0;
        w_tick_d = 1'b1;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk25 or negedge n_p_reset25) begin
    if (!n_p_reset25) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cfg     <= '0;
      r_restart <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_restart <= restart25;
      r_tick    <= w_tick_d;
      if ((r_state == ST_ARM) && (w_state_d == ST_RUN)) begin
        r_cfg <= w_cfg_live;
      end
    end
  end

endmodule
